// File: rtl/soc_monitor_pkg.sv
// Shared types and helpers for the SoC retirement/liveness monitor.
// Holds the run-state encoding and the saturating increment used by every counter.
package soc_monitor_pkg;

  localparam int STATE_W   = 2;
  localparam int SAT_MAX_W = 64;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HANG    = 2'd2,
    TIMEOUT = 2'd3
  } mon_state_e;

  // Counters up to SAT_MAX_W bits wide are widened to SAT_MAX_W, incremented
  // and clamped at the all-ones value of their real width.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] value,
                                                   input int unsigned           width);
    logic [SAT_MAX_W-1:0] max_val;
    max_val = (width >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << width) - SAT_MAX_W'(1));
    return (value >= max_val) ? max_val : value + SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/retire_hart_counter.sv
// Per-hart slice of soc_retire_monitor: instruction count, window sample, hang flag.
// Optional last-PC capture and retire trace with SOC_RETIRE_MONITOR_LASTPC_EN.
module retire_hart_counter
  import soc_monitor_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int PC_W        = 64,
  parameter int WINDOW_LOG2 = 10,
  parameter int HANG_CYCLES = 1024,
  parameter int HART_ID     = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   count_en,
  input  logic                   run,
  input  logic                   wrap,
  input  logic                   retire,
  input  logic [PC_W-1:0]        pc,
  output logic [CNT_W-1:0]       instr_cnt,
  output logic [WINDOW_LOG2:0]   window_cnt,
  output logic                   hang,
  output logic [PC_W-1:0]        last_pc
);

  localparam int WIN_W  = WINDOW_LOG2 + 1;
  localparam int IDLE_W = (HANG_CYCLES > 2) ? $clog2(HANG_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(HANG_CYCLES - 1);

  logic              counted;
  logic [WIN_W-1:0]  acc;
  logic [IDLE_W-1:0] idle_cnt;

  assign counted = count_en & retire;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt  <= '0;
      window_cnt <= '0;
      acc        <= '0;
      idle_cnt   <= '0;
      hang       <= 1'b0;
    end else if (clear) begin
      instr_cnt  <= '0;
      window_cnt <= '0;
      acc        <= '0;
      idle_cnt   <= '0;
      hang       <= 1'b0;
    end else begin
      if (counted) begin
        instr_cnt <= CNT_W'(sat_inc(SAT_MAX_W'(instr_cnt), CNT_W));
      end
      if (run) begin
        // The wrap-cycle retire lands in the published sample, not the next window.
        if (wrap) begin
          window_cnt <= acc + WIN_W'(retire);
          acc        <= '0;
        end else if (retire) begin
          acc <= WIN_W'(sat_inc(SAT_MAX_W'(acc), WIN_W));
        end
        if (retire) begin
          idle_cnt <= '0;
        end else if (idle_cnt == IDLE_LAST) begin
          hang <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + IDLE_W'(1);
        end
      end
    end
  end

`ifdef SOC_RETIRE_MONITOR_LASTPC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pc <= '0;
    end else if (clear) begin
      last_pc <= '0;
    end else if (counted) begin
      last_pc <= pc;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && !clear && counted) begin
      $display("hart %0d pc %h cnt %0d", HART_ID, pc,
               CNT_W'(sat_inc(SAT_MAX_W'(instr_cnt), CNT_W)));
    end
  end
`endif
`else
  assign last_pc = '0;

  logic unused_pc;
  assign unused_pc = ^pc;
`endif

endmodule

// File: rtl/soc_retire_monitor.sv
// Retirement and liveness monitor for multi-hart DandRiscv builds: run FSM, cycle
// and window counters. Define SOC_RETIRE_MONITOR_LASTPC_EN to capture last PCs.
module soc_retire_monitor
  import soc_monitor_pkg::*;
#(
  parameter int NUM_HARTS      = 1,
  parameter int CNT_W          = 32,
  parameter int PC_W           = 64,
  parameter int WINDOW_LOG2    = 10,
  parameter int HANG_CYCLES    = 1024,
  parameter int TIMEOUT_CYCLES = 5500000
) (
  input  logic                                io_axiClk,
  input  logic                                io_asyncResetn,
  input  logic                                io_clear,
  input  logic [NUM_HARTS-1:0]                io_retireValid,
  input  logic [NUM_HARTS*PC_W-1:0]           io_retirePc,
  output logic [NUM_HARTS*CNT_W-1:0]          io_instrCnt,
  output logic [CNT_W-1:0]                    io_cycleCnt,
  output logic [NUM_HARTS*(WINDOW_LOG2+1)-1:0] io_windowCnt,
  output logic [NUM_HARTS-1:0]                io_hang,
  output logic [STATE_W-1:0]                  io_state,
  output logic [NUM_HARTS*PC_W-1:0]           io_lastPc
);

  localparam int WIN_W = WINDOW_LOG2 + 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mon_state_e             state;
  logic [CNT_W-1:0]       cycle_cnt;
  logic [WINDOW_LOG2-1:0] win_cnt;
  logic                   run;
  logic                   count_en;
  logic                   wrap;

  assign run      = (state == RUN);
  assign count_en = (state == IDLE) || run;
  assign wrap     = run && (win_cnt == '1);

  always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      state     <= IDLE;
      cycle_cnt <= '0;
      win_cnt   <= '0;
    end else if (io_clear) begin
      state     <= IDLE;
      cycle_cnt <= '0;
      win_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|io_retireValid) state <= RUN;
        end
        RUN: begin
          cycle_cnt <= CNT_W'(sat_inc(SAT_MAX_W'(cycle_cnt), CNT_W));
          win_cnt   <= win_cnt + WINDOW_LOG2'(1);
          // Timeout is checked first so it wins over a coincident all-hung.
          if (cycle_cnt == TIMEOUT_LAST) begin
            state <= TIMEOUT;
          end else if (&io_hang) begin
            state <= HANG;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_state    = state;
  assign io_cycleCnt = cycle_cnt;

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    retire_hart_counter #(
      .CNT_W      (CNT_W),
      .PC_W       (PC_W),
      .WINDOW_LOG2(WINDOW_LOG2),
      .HANG_CYCLES(HANG_CYCLES),
      .HART_ID    (h)
    ) u_hart (
      .clk       (io_axiClk),
      .rst_n     (io_asyncResetn),
      .clear     (io_clear),
      .count_en  (count_en),
      .run       (run),
      .wrap      (wrap),
      .retire    (io_retireValid[h]),
      .pc        (io_retirePc[h*PC_W +: PC_W]),
      .instr_cnt (io_instrCnt[h*CNT_W +: CNT_W]),
      .window_cnt(io_windowCnt[h*WIN_W +: WIN_W]),
      .hang      (io_hang[h]),
      .last_pc   (io_lastPc[h*PC_W +: PC_W])
    );
  end

endmodule
